// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_bmask;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_bmask,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_bmask,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: captures EX results, runs one data-memory access at a time
// with misalignment and wait-timeout aborts, and issues a registered writeback bundle.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_instr,
    input  logic [31:0] ex_alu_data,
    input  logic [31:0] ex_rs2_data,
    input  logic        ex_mem_wren,
    input  logic        ex_wb_sel,
    input  logic        ex_rd_wren,
    output logic        o_stall,
    mem_stage_if.master dmem,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [4:0]  wb_rd_addr,
    output logic        wb_rd_wren,
    output logic [31:0] wb_data,
    output logic        o_misalign,
    output logic        o_timeout
);

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 32'd1);

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    state_t      state_q;
    logic [7:0]  wait_q;
    logic        req_q, we_q, stall_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  bmask_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        wb_sel_q, rd_wren_q;
    logic [4:0]  rd_q;
    logic [31:0] pc_q, alu_q;
    logic        wb_valid_q, wb_rd_wren_q, misalign_q, timeout_q;
    logic [4:0]  wb_rd_addr_q;
    logic [31:0] wb_pc_q, wb_data_q;

    logic        capture_s, is_mem_s, misalign_s, rd_wren_s;
    logic [1:0]  size_s, off_s;
    logic [31:0] load_data_d;
    logic        unused_s;

    assign capture_s  = ex_valid & ~stall_q;
    assign is_mem_s   = (ex_instr[6:0] == 7'b0000011) | ex_mem_wren;
    assign size_s     = ex_instr[13:12];
    assign off_s      = ex_alu_data[1:0];
    assign misalign_s = ((size_s == 2'b01) & off_s[0]) | (size_s[1] & (off_s != 2'b00));
    assign rd_wren_s  = ex_rd_wren & (ex_instr[11:7] != 5'd0);
    assign unused_s   = ^ex_instr[31:15];

    // Load data is extracted from the bus word using the captured size and byte offset.
    always_comb begin
        load_data_d = load_extract(f3_q, off_q, dmem.dmem_rdata);
    end

    // Stage FSM: capture, memory access with timeout, and registered writeback/error outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            wait_q       <= 8'd0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            stall_q      <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            bmask_q      <= 4'd0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
            wb_sel_q     <= 1'b0;
            rd_wren_q    <= 1'b0;
            rd_q         <= 5'd0;
            pc_q         <= 32'd0;
            alu_q        <= 32'd0;
            wb_valid_q   <= 1'b0;
            wb_rd_wren_q <= 1'b0;
            wb_rd_addr_q <= 5'd0;
            wb_pc_q      <= 32'd0;
            wb_data_q    <= 32'd0;
            misalign_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (capture_s) begin
                        f3_q      <= ex_instr[14:12];
                        off_q     <= off_s;
                        wb_sel_q  <= ex_wb_sel;
                        rd_wren_q <= rd_wren_s;
                        rd_q      <= ex_instr[11:7];
                        pc_q      <= ex_pc;
                        alu_q     <= ex_alu_data;
                        if (is_mem_s && !misalign_s) begin
                            state_q <= ACCESS;
                            wait_q  <= 8'd0;
                            req_q   <= 1'b1;
                            stall_q <= 1'b1;
                            we_q    <= ex_mem_wren;
                            addr_q  <= {ex_alu_data[31:2], 2'b00};
                            wdata_q <= store_data(size_s, ex_rs2_data);
                            bmask_q <= ex_mem_wren ? store_mask(size_s, off_s) : 4'b1111;
                        end else begin
                            // Non-memory ops complete at once; misaligned ones complete without a write.
                            wb_valid_q   <= 1'b1;
                            wb_pc_q      <= ex_pc;
                            wb_rd_addr_q <= ex_instr[11:7];
                            wb_data_q    <= ex_alu_data;
                            wb_rd_wren_q <= rd_wren_s & ~(is_mem_s & misalign_s);
                            misalign_q   <= is_mem_s & misalign_s;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem.dmem_ack || (wait_q == WAIT_LAST)) begin
                        state_q      <= IDLE;
                        req_q        <= 1'b0;
                        we_q         <= 1'b0;
                        stall_q      <= 1'b0;
                        wb_valid_q   <= 1'b1;
                        wb_pc_q      <= pc_q;
                        wb_rd_addr_q <= rd_q;
                        wb_data_q    <= (wb_sel_q && dmem.dmem_ack) ? load_data_d : alu_q;
                        wb_rd_wren_q <= rd_wren_q & dmem.dmem_ack;
                        timeout_q    <= ~dmem.dmem_ack;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_stall          = stall_q;
    assign dmem.dmem_req    = req_q;
    assign dmem.dmem_we     = we_q;
    assign dmem.dmem_addr   = addr_q;
    assign dmem.dmem_wdata  = wdata_q;
    assign dmem.dmem_bmask  = bmask_q;
    assign wb_valid         = wb_valid_q;
    assign wb_pc            = wb_pc_q;
    assign wb_rd_addr       = wb_rd_addr_q;
    assign wb_rd_wren       = wb_rd_wren_q;
    assign wb_data          = wb_data_q;
    assign o_misalign       = misalign_q;
    assign o_timeout        = timeout_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level reference model.
module tb_mem_stage;
    localparam int MW = 15;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_instr, ex_alu_data, ex_rs2_data;
    logic        ex_mem_wren, ex_wb_sel, ex_rd_wren;
    logic        o_stall;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_wren;
    logic [31:0] wb_data;
    logic        o_misalign, o_timeout;

    int n_total = 0;
    int n_bad   = 0;

    mem_stage_if bus ();

    mem_stage #(.MAX_WAIT(MW)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_instr    (ex_instr),
        .ex_alu_data (ex_alu_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_mem_wren (ex_mem_wren),
        .ex_wb_sel   (ex_wb_sel),
        .ex_rd_wren  (ex_rd_wren),
        .o_stall     (o_stall),
        .dmem        (bus.master),
        .wb_valid    (wb_valid),
        .wb_pc       (wb_pc),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_wren  (wb_rd_wren),
        .wb_data     (wb_data),
        .o_misalign  (o_misalign),
        .o_timeout   (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: the addressed byte/halfword as a number, sign-extended arithmetically when signed.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * off);
        if (f3[1:0] == 2'b00) begin
            v = v % 32'd256;
            if (!f3[2] && v >= 32'd128) v = v - 32'd256;
        end else if (f3[1:0] == 2'b01) begin
            v = v % 32'd65536;
            if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_mask(input logic [2:0] f3, input int off);
        if (f3[1:0] == 2'b00) return 32'(1 << off);
        if (f3[1:0] == 2'b01) return 32'(3 << (off - (off % 2)));
        return 32'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        if (f3[1:0] == 2'b00) return (rs2 % 32'd256) * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return (rs2 % 32'd65536) * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input int off);
        if (f3[1:0] == 2'b00) return 1'b0;
        if (f3[1:0] == 2'b01) return (off % 2) != 0;
        return off != 0;
    endfunction

    // kind: 0 = ALU op, 1 = load, 2 = store. ackd = ACCESS cycles before ack (>= MW means never).
    task automatic run_op(input int kind, input logic [2:0] f3, input logic [4:0] rd, input logic wren,
                          input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] rdata,
                          input int ackd);
        logic [31:0] r, pc, exp_data;
        logic [6:0]  opc;
        int off, stalls;
        bit mem, mis, done, exp_wren;
        r   = $urandom;
        pc  = $urandom;
        opc = (kind == 1) ? 7'b0000011 : (kind == 2) ? 7'b0100011 : 7'b0110011;
        off = int'(alu % 32'd4);
        mem = (kind != 0);
        mis = mem && ref_misaligned(f3, off);
        exp_wren = wren && (rd != 5'd0);

        ex_valid    = 1'b1;
        ex_pc       = pc;
        ex_instr    = {r[31:15], f3, rd, opc};
        ex_alu_data = alu;
        ex_rs2_data = rs2;
        ex_mem_wren = (kind == 2);
        ex_wb_sel   = (kind == 1);
        ex_rd_wren  = wren;
        @(posedge i_clk);
        #1;
        ex_valid = 1'b0;

        if (!mem || mis) begin
            chk("imm_wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("imm_wb_data", wb_data, alu);
            chk("imm_wb_pc", wb_pc, pc);
            chk("imm_wb_rd", {27'd0, wb_rd_addr}, {27'd0, rd});
            chk("imm_wb_wren", {31'd0, wb_rd_wren}, (mis ? 32'd0 : {31'd0, exp_wren}));
            chk("imm_misalign", {31'd0, o_misalign}, {31'd0, mis});
            chk("imm_no_req", {31'd0, bus.dmem_req}, 32'd0);
            chk("imm_no_stall", {31'd0, o_stall}, 32'd0);
        end else begin
            chk("acc_addr", bus.dmem_addr, alu - 32'(off));
            chk("acc_we", {31'd0, bus.dmem_we}, (kind == 2) ? 32'd1 : 32'd0);
            chk("acc_bmask", {28'd0, bus.dmem_bmask}, (kind == 2) ? ref_mask(f3, off) : 32'd15);
            if (kind == 2) chk("acc_wdata", bus.dmem_wdata, ref_wdata(f3, rs2));
            stalls = 0;
            done   = 1'b0;
            for (int i = 0; i < MW && !done; i++) begin
                chk("acc_req", {31'd0, bus.dmem_req}, 32'd1);
                chk("acc_no_wb", {31'd0, wb_valid}, 32'd0);
                stalls += int'(o_stall);
                if (i == ackd) begin
                    bus.dmem_ack   = 1'b1;
                    bus.dmem_rdata = rdata;
                end
                @(posedge i_clk);
                #1;
                bus.dmem_ack = 1'b0;
                if (i == ackd) begin
                    done = 1'b1;
                    exp_data = (kind == 1) ? ref_load(f3, off, rdata) : alu;
                    chk("ack_wb_valid", {31'd0, wb_valid}, 32'd1);
                    chk("ack_wb_data", wb_data, exp_data);
                    chk("ack_wb_wren", {31'd0, wb_rd_wren}, {31'd0, exp_wren});
                    chk("ack_wb_rd", {27'd0, wb_rd_addr}, {27'd0, rd});
                    chk("ack_wb_pc", wb_pc, pc);
                    chk("ack_no_timeout", {31'd0, o_timeout}, 32'd0);
                end
            end
            if (!done) begin
                chk("to_pulse", {31'd0, o_timeout}, 32'd1);
                chk("to_wb_valid", {31'd0, wb_valid}, 32'd1);
                chk("to_wb_wren", {31'd0, wb_rd_wren}, 32'd0);
            end
            chk("end_req", {31'd0, bus.dmem_req}, 32'd0);
            chk("end_stall", {31'd0, o_stall}, 32'd0);
            chk("stall_cycles", 32'(stalls), done ? 32'(ackd + 1) : 32'(MW));
        end

        @(posedge i_clk);
        #1;
        chk("idle_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("idle_pulses", {30'd0, o_misalign, o_timeout}, 32'd0);
        chk("idle_req", {31'd0, bus.dmem_req}, 32'd0);
    endtask

    initial begin
        int kind, ackd, sel;
        logic [2:0] f3;
        logic [31:0] alu;
        logic [2:0] load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        i_reset        = 1'b1;
        ex_valid       = 1'b0;
        ex_pc          = 32'd0;
        ex_instr       = 32'd0;
        ex_alu_data    = 32'd0;
        ex_rs2_data    = 32'd0;
        ex_mem_wren    = 1'b0;
        ex_wb_sel      = 1'b0;
        ex_rd_wren     = 1'b0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'd0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_outputs", {27'd0, wb_valid, bus.dmem_req, o_stall, o_misalign, o_timeout}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_addr", bus.dmem_addr, 32'd0);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        // Ack while idle must be ignored.
        bus.dmem_ack = 1'b1;
        @(posedge i_clk);
        #1;
        bus.dmem_ack = 1'b0;
        chk("idle_ack_ignored", {30'd0, wb_valid, bus.dmem_req}, 32'd0);

        run_op(0, 3'd0, 5'd5, 1'b1, 32'h0000_1234, 32'd0, 32'd0, 0);
        run_op(2, 3'd0, 5'd0, 1'b0, 32'h0000_0103, 32'h0000_00AB, 32'd0, 2);
        run_op(1, 3'd1, 5'd7, 1'b1, 32'h0000_0202, 32'd0, 32'h8001_0000, 0);
        run_op(1, 3'd5, 5'd7, 1'b1, 32'h0000_0202, 32'd0, 32'h8001_0000, 0);
        run_op(1, 3'd2, 5'd9, 1'b1, 32'h0000_0106, 32'd0, 32'd0, 0);
        run_op(1, 3'd2, 5'd9, 1'b1, 32'h0000_0100, 32'd0, 32'd0, 100);
        run_op(0, 3'd0, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'd0, 32'd0, 0);

        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 2));
            sel  = int'($urandom_range(0, 4));
            f3   = (kind == 1) ? load_f3[sel] : 3'(sel % 3);
            alu  = $urandom;
            if ($urandom_range(0, 1) == 0) alu = alu & 32'hFFFF_FFFC;
            ackd = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 5));
            run_op(kind, f3, 5'($urandom_range(0, 31)),
                   (kind == 1) ? 1'b1 : (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1)),
                   alu, $urandom, $urandom, ackd);
        end

        // Reset in the middle of an access, between clock edges.
        ex_valid    = 1'b1;
        ex_instr    = {17'd0, 3'd2, 5'd3, 7'b0000011};
        ex_alu_data = 32'h0000_0400;
        ex_mem_wren = 1'b0;
        ex_wb_sel   = 1'b1;
        ex_rd_wren  = 1'b1;
        @(posedge i_clk);
        #1;
        ex_valid = 1'b0;
        chk("mid_req_before", {31'd0, bus.dmem_req}, 32'd1);
        @(posedge i_clk);
        #3;
        i_reset = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, o_stall}, 32'd0);
        @(posedge i_clk);
        #1;
        i_reset      = 1'b0;
        bus.dmem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge i_clk);
            #1;
            bus.dmem_ack = 1'b0;
            chk("post_rst_no_wb", {30'd0, wb_valid, bus.dmem_req}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
